uart_prog_loader: RTL

//  Loads a program image into the instruction ROM over UART, so the CPU can be

---
 rtl/uart_prog_loader_pkg.sv | 18 +
 rtl/uart_prog_loader_rx_byte.sv | 102 ++++++++++
 rtl/uart_prog_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and elaboration helpers for the UART program loader.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  function automatic int unsigned calc_bit_div(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_tmr_w(input int unsigned idle_to,
                                             input int unsigned bit_div);
    return $clog2(idle_to * bit_div + 1);
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 byte receiver: synchronises rx, validates the start bit at half a bit, samples mid-bit.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned BitDiv = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       start_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o
);

  localparam int unsigned CntW = $clog2(BitDiv);
  localparam logic [CntW-1:0] CntHalf = CntW'(BitDiv / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BitDiv - 1);

  rx_state_e       state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            start_q, start_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    start_d = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d = RxStart;
          start_d = 1'b1;
        end
      end
      RxStart: begin
        // A line that has gone high again by half a bit was only a glitch.
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          ferr_d  = !sync2_q;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      start_q <= start_d;
    end
  end

  assign start_o    = start_q;
  assign rx_valid_o = valid_q;
  assign rx_data_o  = shift_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads little-endian 32-bit words from UART into the instruction ROM, holding the CPU in reset.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned IDLE_TO  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              uart_rx,
  output logic              upg_wen,
  output logic [ADDR_W-1:0] upg_adr,
  output logic [31:0]       upg_dat,
  output logic              cpu_hold,
  output logic              upg_done,
  output logic              load_err
);

  localparam int unsigned BitDiv     = calc_bit_div(CLK_FREQ, BAUD);
  localparam int unsigned TmrW       = calc_tmr_w(IDLE_TO, BitDiv);
  localparam int unsigned IdleCycles = IDLE_TO * BitDiv;
  localparam logic [ADDR_W-1:0] AddrMax = '1;

  logic       rx_start, rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx_byte #(
    .BitDiv(BitDiv)
  ) u_rx (
    .clk_i     (clock),
    .rst_i     (reset),
    .rx_i      (uart_rx),
    .start_o   (rx_start),
    .rx_valid_o(rx_valid),
    .rx_data_o (rx_data),
    .rx_ferr_o (rx_ferr)
  );

  state_e            state_q, state_d;
  logic [2:0]        start_s_q, start_s_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              armed_q, armed_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_edge;

  assign start_edge = start_s_q[1] & ~start_s_q[2];

  always_comb begin
    start_s_d = {start_s_q[1:0], start_pg};
    state_d   = state_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    tmr_d     = tmr_q;
    armed_d   = armed_q;
    wen_d     = 1'b0;
    adr_d     = adr_q;
    dat_d     = dat_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d = StLoad;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          bcnt_d  = '0;
          tmr_d   = '0;
          armed_d = 1'b0;
        end
      end
      StLoad: begin
        // Idle time is measured from the last line activity, once data has started flowing.
        if (rx_start || rx_valid) tmr_d = '0;
        else if (armed_q) tmr_d = tmr_q + 1'b1;
        if (rx_valid) begin
          armed_d = 1'b1;
          if (rx_ferr) begin
            err_d = 1'b1;
          end else begin
            word_d[{bcnt_q, 3'b000} +: 8] = rx_data;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              wen_d = 1'b1;
              adr_d = addr_q;
              dat_d = {rx_data, word_q[23:0]};
              if (addr_q == AddrMax) begin
                state_d = StDone;
                hold_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end
          end
        end else if (!rx_start && armed_q && tmr_q == TmrW'(IdleCycles - 1)) begin
          state_d = StDone;
          hold_d  = 1'b0;
          done_d  = 1'b1;
          if (bcnt_q != 2'd0) err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_s_q <= '0;
      state_q   <= StIdle;
      addr_q    <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      tmr_q     <= '0;
      armed_q   <= 1'b0;
      wen_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_s_q <= start_s_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      tmr_q     <= tmr_d;
      armed_q   <= armed_d;
      wen_q     <= wen_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign upg_wen  = wen_q;
  assign upg_adr  = adr_q;
  assign upg_dat  = dat_q;
  assign cpu_hold = hold_q;
  assign upg_done = done_q;
  assign load_err = err_q;

endmodule
